// File: rtl/reg_file_mp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_pkg
//  Description : Shared types, defaults and slicing helpers for reg_file_mp.
//  Revision    : 1.0 - initial multi-port release
// ============================================================================
package regfile_pkg;

    // Clear engine states: idle, or sweeping one entry per cycle
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;

    // LSB position of port 'port' inside a flattened bus of 'width'-bit fields
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_file_mp_if.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp_if
//  Description : Read/write/clear bus of the multi-port register file.
//                master = decode/writeback/flush side, slave = register file.
//  Revision    : 1.0 - initial multi-port release
// ============================================================================
interface reg_file_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 1
);
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_WR-1:0]        wr_en;
    logic [NUM_WR*ADDR_W-1:0] wr_addr;
    logic [NUM_WR*DATA_W-1:0] wr_data;
    logic                     wr_ready;
    logic                     clr_req;
    logic                     clr_busy;
    logic                     clr_done;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, wr_ready, clr_busy, clr_done
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, wr_ready, clr_busy, clr_done
    );

endinterface
`default_nettype wire

// File: rtl/reg_file_mp_wr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wr_arb
//  Description : Resolves, for every register entry, whether some write port
//                targets it and which data wins (highest port index wins).
//                Feeds both the array update and the read bypass so the two
//                can never disagree on priority.
//  Revision    : 1.0 - initial multi-port release
// ============================================================================
module regfile_wr_arb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NUM_WR = 1
) (
    input  wire logic [NUM_WR-1:0]                  i_wr_en,
    input  wire logic [NUM_WR*ADDR_W-1:0]           i_wr_addr,
    input  wire logic [NUM_WR*DATA_W-1:0]           i_wr_data,
    output logic      [(1<<ADDR_W)-1:0]             o_hit,
    output logic      [(1<<ADDR_W)*DATA_W-1:0]      o_data
);
    localparam int DEPTH = 1 << ADDR_W;

    // Ascending port scan: a later (higher) port overrides an earlier one
    always_comb begin
        o_hit  = '0;
        o_data = '0;
        for (int e = 0; e < DEPTH; e++) begin
            for (int w = 0; w < NUM_WR; w++) begin
                if (i_wr_en[w] && (i_wr_addr[w*ADDR_W +: ADDR_W] == ADDR_W'(e))) begin
                    o_hit[e]                  = 1'b1;
                    o_data[e*DATA_W +: DATA_W] = i_wr_data[w*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : reg_file_mp
//  Description : Parametrised multi-port register file. Registered reads with
//                optional write-to-read bypass, optional hardwired zero entry,
//                and a sequential soft-clear sweep (one entry per cycle).
//  Revision    : 1.0 - initial multi-port release
// ============================================================================
module reg_file_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int NUM_WR   = 1,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  wire logic    clk,
    input  wire logic    rstn,
    reg_file_mp_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [0:0] ST_IDLE  = IDLE;
    localparam logic [0:0] ST_CLEAR = CLEAR;

    logic [0:0]               r_state;
    logic [ADDR_W-1:0]        r_ptr;
    logic                     w_busy;
    logic                     w_last;
    logic [NUM_WR-1:0]        w_wr_en_acc;
    logic [DEPTH-1:0]         w_hit;
    logic [DEPTH*DATA_W-1:0]  w_hit_data;
    logic [DATA_W-1:0]        r_mem [DEPTH];
    logic [NUM_RD*DATA_W-1:0] w_rd_flat;

    assign w_busy = (r_state == ST_CLEAR);
    assign w_last = w_busy && (r_ptr == ADDR_W'(DEPTH - 1));

    // Writes are only accepted while the clear engine is idle
    assign w_wr_en_acc = bus.wr_en & {NUM_WR{~w_busy}};

    assign bus.wr_ready = ~w_busy;
    assign bus.clr_busy = w_busy;
    assign bus.clr_done = w_last;
    assign bus.rd_data  = w_rd_flat;

    regfile_wr_arb #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .NUM_WR (NUM_WR)
    ) u_wr_arb (
        .i_wr_en   (w_wr_en_acc),
        .i_wr_addr (bus.wr_addr),
        .i_wr_data (bus.wr_data),
        .o_hit     (w_hit),
        .o_data    (w_hit_data)
    );

    // Clear engine: request sampled in IDLE, sweep ptr 0..DEPTH-1, then back to IDLE
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.clr_req) begin
                        r_state <= ST_CLEAR;
                        r_ptr   <= '0;
                    end
                end
                ST_CLEAR: begin
                    r_ptr <= r_ptr + 1'b1;
                    if (w_last) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    // Storage update: sweep clears the pointed entry, otherwise the winning write lands
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int e = 0; e < DEPTH; e++) begin
                r_mem[e] <= '0;
            end
        end else begin
            for (int e = 0; e < DEPTH; e++) begin
                if (w_busy && (r_ptr == ADDR_W'(e))) begin
                    r_mem[e] <= '0;
                end else if (w_hit[e] && !((ZERO_REG != 0) && (e == 0))) begin
                    r_mem[e] <= w_hit_data[e*DATA_W +: DATA_W];
                end
            end
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] w_raddr;
        logic [DATA_W-1:0] w_rnext;
        logic [DATA_W-1:0] r_q;

        assign w_raddr = bus.rd_addr[port_lsb(p, ADDR_W) +: ADDR_W];

        // Read source priority: sweep -> zero entry -> same-cycle write -> array
        always_comb begin
            w_rnext = r_mem[w_raddr];
            if (w_busy) begin
                w_rnext = '0;
            end else if ((ZERO_REG != 0) && (w_raddr == '0)) begin
                w_rnext = '0;
            end else if ((BYPASS != 0) && w_hit[w_raddr]) begin
                w_rnext = w_hit_data[int'(w_raddr)*DATA_W +: DATA_W];
            end
        end

        // Output register only loads on an enabled read, otherwise holds
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_q <= '0;
            end else if (bus.rd_en[p]) begin
                r_q <= w_rnext;
            end
        end

        assign w_rd_flat[port_lsb(p, DATA_W) +: DATA_W] = r_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_reg_file_mp.sv
`default_nettype none
// ============================================================================
//  Module      : tb_reg_file_mp
//  Description : Self-checking bench for reg_file_mp (2 read, 2 write ports,
//                zero register and bypass enabled) against an array model.
//  Revision    : 1.0 - initial multi-port release
// ============================================================================
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int ZR    = 1;
    localparam int BP    = 1;
    localparam int DEPTH = 1 << AW;

    logic clk;
    logic rstn;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR)) bus ();

    reg_file_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NRD), .NUM_WR(NWR),
        .ZERO_REG(ZR), .BYPASS(BP)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: register contents, clear progress, expected read outputs
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_busy;
    int            m_left;
    logic [DW-1:0] m_rd  [NRD];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.rd_en   = '0;
        bus.rd_addr = '0;
        bus.wr_en   = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;
        bus.clr_req = 1'b0;
    endtask

    task automatic set_wr(input int w, input int a, input logic [DW-1:0] d);
        bus.wr_en[w]             = 1'b1;
        bus.wr_addr[w*AW +: AW]  = AW'(a);
        bus.wr_data[w*DW +: DW]  = d;
    endtask

    task automatic set_rd(input int p, input int a);
        bus.rd_en[p]            = 1'b1;
        bus.rd_addr[p*AW +: AW] = AW'(a);
    endtask

    function automatic logic [DW-1:0] rd_out(input int p);
        return bus.rd_data[p*DW +: DW];
    endfunction

    // One clock with the currently driven inputs; model advanced alongside
    task automatic step();
        logic [DW-1:0] nm [DEPTH];
        int a;
        int w;
        bit hit;
        chk("wr_ready", 32'(bus.wr_ready), 32'(!m_busy));
        chk("clr_busy", 32'(bus.clr_busy), 32'(m_busy));
        chk("clr_done", 32'(bus.clr_done), 32'(m_busy && (m_left == 1)));
        nm = m_mem;
        if (!m_busy) begin
            for (int i = 0; i < NWR; i++) begin
                a = int'(bus.wr_addr[i*AW +: AW]);
                if (bus.wr_en[i] && !(ZR != 0 && a == 0)) nm[a] = bus.wr_data[i*DW +: DW];
            end
        end
        for (int p = 0; p < NRD; p++) begin
            if (bus.rd_en[p]) begin
                a = int'(bus.rd_addr[p*AW +: AW]);
                if (m_busy || (ZR != 0 && a == 0)) begin
                    m_rd[p] = '0;
                end else begin
                    m_rd[p] = m_mem[a];
                    hit = 1'b0;
                    w = NWR - 1;
                    while (BP != 0 && !hit && w >= 0) begin
                        if (bus.wr_en[w] && int'(bus.wr_addr[w*AW +: AW]) == a) begin
                            m_rd[p] = bus.wr_data[w*DW +: DW];
                            hit = 1'b1;
                        end
                        w--;
                    end
                end
            end
        end
        if (m_busy) begin
            nm[DEPTH - m_left] = '0;
            m_left--;
            if (m_left == 0) m_busy = 1'b0;
        end else if (bus.clr_req) begin
            m_busy = 1'b1;
            m_left = DEPTH;
        end
        m_mem = nm;
        @(posedge clk);
        #1;
        for (int p = 0; p < NRD; p++) chk($sformatf("rd_data[%0d]", p), rd_out(p), m_rd[p]);
        idle_inputs();
    endtask

    // Asynchronous reset applied between edges, released away from an edge
    task automatic do_reset();
        rstn = 1'b0;
        #1;
        for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        for (int p = 0; p < NRD; p++) m_rd[p] = '0;
        m_busy = 1'b0;
        m_left = 0;
        chk("rst clr_busy", 32'(bus.clr_busy), 32'd0);
        chk("rst clr_done", 32'(bus.clr_done), 32'd0);
        for (int p = 0; p < NRD; p++) chk("rst rd_data", rd_out(p), 32'd0);
        @(posedge clk);
        #2;
        rstn = 1'b1;
        chk("rst wr_ready", 32'(bus.wr_ready), 32'd1);
    endtask

    // Sweep every entry through both read ports
    task automatic read_all();
        for (int a = 0; a < DEPTH; a += 2) begin
            set_rd(0, a);
            set_rd(1, a + 1);
            step();
        end
    endtask

    int nb;
    int nd;

    initial begin
        rstn = 1'b0;
        idle_inputs();
        #3;
        do_reset();

        // T2: write then read latency; zero entry
        set_wr(0, 3, 32'h12345678); step();
        set_rd(0, 3); step();
        chk("T2 r3", rd_out(0), 32'h12345678);
        set_wr(0, 0, 32'hFF); step();
        set_rd(1, 0); step();
        chk("T2 r0", rd_out(1), 32'h0);

        // T3: same-cycle write and read of r7
        set_wr(0, 7, 32'h11); step();
        set_wr(0, 7, 32'hA5A5A5A5); set_rd(0, 7); step();
        chk("T3 bypass", rd_out(0), 32'hA5A5A5A5);

        // T4: both write ports hit r9, higher port wins
        set_wr(0, 9, 32'h1); set_wr(1, 9, 32'h2); set_rd(1, 9); step();
        chk("T4 bypass", rd_out(1), 32'h2);
        set_rd(0, 9); step();
        chk("T4 array", rd_out(0), 32'h2);

        // T1: reset wipes a written entry
        set_wr(1, 5, 32'hDEAD); step();
        do_reset();
        set_rd(0, 5); step();
        chk("T1 r5", rd_out(0), 32'h0);

        // T5: fill, sweep, dropped mid-sweep write
        for (int i = 1; i < DEPTH; i += 2) begin
            set_wr(0, i, DW'(i));
            if (i + 1 < DEPTH) set_wr(1, i + 1, DW'(i + 1));
            step();
        end
        read_all();
        bus.clr_req = 1'b1; step();
        nb = 0; nd = 0;
        for (int c = 0; c < DEPTH + 4; c++) begin
            if (c == 5) begin set_wr(0, 4, 32'h99); set_rd(0, 4); end
            if (bus.clr_busy === 1'b1) nb++;
            if (bus.clr_done === 1'b1) nd++;
            step();
        end
        chk("T5 busy cycles", 32'(nb), 32'(DEPTH));
        chk("T5 done pulses", 32'(nd), 32'd1);
        read_all();

        // T6: reset at sweep cycle 10
        for (int i = 1; i < 8; i++) begin set_wr(0, i, 32'hC0DE0000 | DW'(i)); step(); end
        bus.clr_req = 1'b1; step();
        for (int c = 0; c < 10; c++) step();
        do_reset();
        nd = 0;
        for (int c = 0; c < 4; c++) begin
            if (bus.clr_done === 1'b1) nd++;
            step();
        end
        chk("T6 no done", 32'(nd), 32'd0);
        read_all();

        // Randomised traffic with occasional clears
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < NRD; p++) begin
                bus.rd_en[p] = 1'($urandom_range(0, 1));
                bus.rd_addr[p*AW +: AW] = AW'($urandom_range(0, (c % 2 == 0) ? 7 : DEPTH - 1));
            end
            for (int w = 0; w < NWR; w++) begin
                bus.wr_en[w] = 1'($urandom_range(0, 1));
                bus.wr_addr[w*AW +: AW] = AW'($urandom_range(0, (c % 2 == 0) ? 7 : DEPTH - 1));
                bus.wr_data[w*DW +: DW] = DW'($urandom);
            end
            bus.clr_req = ($urandom_range(0, 59) == 0);
            step();
        end
        for (int c = 0; c < DEPTH + 2; c++) step();
        read_all();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
